// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared widths, FPU latency default, operation encodings and
//               the issue-tracking record used by the FPU issue arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    localparam int DATA_W          = 32;
    localparam int FPU_LAT_DEFAULT = 6;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } fpu_op_e;

    typedef struct packed {
        logic vld;
        logic id;
    } trk_t;

endpackage
`default_nettype wire

// File: rtl/rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rsp_fifo
// Description : Synchronous FIFO with asynchronous reset; the head word is
//               forced to zero whenever the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module rsp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic [WIDTH-1:0]                 push_data,
    input  logic                             pop_req,
    output logic                             valid,
    output logic [WIDTH-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]       count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_full;

    assign valid  = (r_count != '0);
    assign w_full = (r_count == CW'(DEPTH));
    assign w_pop  = pop_req && valid;
    assign head   = valid ? r_mem[r_rd_ptr] : '0;
    assign count  = r_count;

    // Storage carries no reset; only the pointers and count define content.
    always_ff @(posedge clk) begin
        if (push && !w_full) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push && !w_full) begin
                r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({push && !w_full, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && w_full));

endmodule
`default_nettype wire

// File: rtl/fpu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpu_issue_arbiter
// Description : Round-robin issue of two requesters onto one pipelined FPU,
//               with credit-based flow control into an in-order response FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_issue_arbiter #(
    parameter int DATA_W    = fpu_pkg::DATA_W,
    parameter int FPU_LAT   = fpu_pkg::FPU_LAT_DEFAULT,
    parameter int RSP_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_op1,
    input  logic [DATA_W-1:0] req0_op2,
    input  logic [1:0]        req0_operation,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_op1,
    input  logic [DATA_W-1:0] req1_op2,
    input  logic [1:0]        req1_operation,
    output logic [DATA_W-1:0] fpu_op1,
    output logic [DATA_W-1:0] fpu_op2,
    output logic [1:0]        fpu_operation,
    input  logic [DATA_W-1:0] fpu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
);

    import fpu_pkg::*;

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    logic             r_rr_ptr;
    logic [CNT_W-1:0] r_inflight;
    trk_t             r_trk [FPU_LAT];
    logic [CNT_W-1:0] w_fifo_count;
    logic             w_issue_ok;
    logic             w_grant;
    logic             w_grant_id;
    logic             w_last_vld;
    logic [DATA_W:0]  w_rsp_head;

    // Credit = RSP_DEPTH - (inflight + fifo_count) > 0.
    assign w_issue_ok = ({1'b0, r_inflight} + {1'b0, w_fifo_count}) < (CNT_W + 1)'(RSP_DEPTH);

    always_comb begin
        w_grant    = 1'b0;
        w_grant_id = 1'b0;
        if (!rst && w_issue_ok) begin
            if (r_rr_ptr ? req1_valid : req0_valid) begin
                w_grant    = 1'b1;
                w_grant_id = r_rr_ptr;
            end else if (r_rr_ptr ? req0_valid : req1_valid) begin
                w_grant    = 1'b1;
                w_grant_id = ~r_rr_ptr;
            end
        end
    end

    assign req0_ready = w_grant && !w_grant_id;
    assign req1_ready = w_grant &&  w_grant_id;

    always_comb begin
        fpu_op1       = '0;
        fpu_op2       = '0;
        fpu_operation = OP_ADD;
        if (w_grant) begin
            fpu_op1       = w_grant_id ? req1_op1       : req0_op1;
            fpu_op2       = w_grant_id ? req1_op2       : req0_op2;
            fpu_operation = w_grant_id ? req1_operation : req0_operation;
        end
    end

    assign w_last_vld = r_trk[FPU_LAT-1].vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr   <= 1'b0;
            r_inflight <= '0;
            for (int i = 0; i < FPU_LAT; i++) begin
                r_trk[i] <= '0;
            end
        end else begin
            if (w_grant) begin
                r_rr_ptr <= ~r_rr_ptr;
            end
            r_trk[0] <= '{vld: w_grant, id: w_grant_id};
            for (int i = 1; i < FPU_LAT; i++) begin
                r_trk[i] <= r_trk[i-1];
            end
            case ({w_grant, w_last_vld})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    rsp_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_last_vld),
        .push_data ({r_trk[FPU_LAT-1].id, fpu_result}),
        .pop_req   (rsp_ready),
        .valid     (rsp_valid),
        .head      (w_rsp_head),
        .count     (w_fifo_count)
    );

    assign rsp_id   = w_rsp_head[DATA_W];
    assign rsp_data = w_rsp_head[DATA_W-1:0];
    assign busy     = (r_inflight != '0) || (w_fifo_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_issue_arbiter
// Description : Directed self-checking bench for fpu_issue_arbiter with a
//               fixed-latency mock FPU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_issue_arbiter;

    localparam int DW  = 32;
    localparam int LAT = 6;
    localparam int DEP = 8;

    logic          clk;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [1:0]    req0_operation, req1_operation;
    logic [DW-1:0] fpu_op1, fpu_op2;
    logic [1:0]    fpu_operation;
    logic [DW-1:0] fpu_result;
    logic          rsp_valid, rsp_ready, rsp_id;
    logic [DW-1:0] rsp_data;
    logic          busy;

    int            vectors;
    int            miscompares;
    logic [DW:0]   exp_q [$];
    logic [DW-1:0] fpu_pipe [LAT];

    fpu_issue_arbiter #(
        .DATA_W    (DW),
        .FPU_LAT   (LAT),
        .RSP_DEPTH (DEP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_op1       (req0_op1),
        .req0_op2       (req0_op2),
        .req0_operation (req0_operation),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_op1       (req1_op1),
        .req1_op2       (req1_op2),
        .req1_operation (req1_operation),
        .fpu_op1        (fpu_op1),
        .fpu_op2        (fpu_op2),
        .fpu_operation  (fpu_operation),
        .fpu_result     (fpu_result),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_data       (rsp_data),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mock FPU: real result for 1.0 + 2.0, otherwise an integer-sum signature.
    function automatic logic [DW-1:0] fpu_model(input logic [1:0] op,
                                                input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        if (op == 2'b00 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a + b + {30'd0, op};
    endfunction

    always @(posedge clk) begin
        fpu_pipe[0] <= fpu_model(fpu_operation, fpu_op1, fpu_op2);
        for (int i = 1; i < LAT; i++) fpu_pipe[i] <= fpu_pipe[i-1];
    end
    assign fpu_result = fpu_pipe[LAT-1];

    task automatic clear_inputs();
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_op1 = '0; req0_op2 = '0; req0_operation = '0;
        req1_op1 = '0; req1_op2 = '0; req1_operation = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1;
        req0_valid = 1; req1_valid = 1; rsp_ready = 1;
        req0_op1 = 32'h1111_1111; req0_op2 = 32'h2222_2222; req0_operation = 2'b11;
        req1_op1 = 32'h3333_3333; req1_op2 = 32'h4444_4444; req1_operation = 2'b10;
        #1;
        vectors++; if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL reset_req0_ready got=%b want=0", req0_ready); end
        vectors++; if (req1_ready !== 1'b0) begin miscompares++; $display("FAIL reset_req1_ready got=%b want=0", req1_ready); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        vectors++; if ({rsp_id, rsp_data} !== 33'd0) begin miscompares++; $display("FAIL reset_rsp got=%h want=0", {rsp_id, rsp_data}); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy); end
        vectors++; if ({fpu_op1, fpu_op2, fpu_operation} !== 66'd0) begin miscompares++; $display("FAIL reset_fpu got=%h/%h/%b want=0", fpu_op1, fpu_op2, fpu_operation); end
        do_reset();
    endtask

    task automatic test_single_op();
        do_reset();
        @(negedge clk);
        req0_valid = 1; req0_op1 = 32'h3F80_0000; req0_op2 = 32'h4000_0000; req0_operation = 2'b00;
        #1;
        vectors++; if ({req0_ready, req1_ready} !== 2'b10) begin miscompares++; $display("FAIL single_ready got=%b want=10", {req0_ready, req1_ready}); end
        vectors++; if ({fpu_op1, fpu_op2, fpu_operation} !== {32'h3F80_0000, 32'h4000_0000, 2'b00}) begin
            miscompares++; $display("FAIL single_fpu_drive got=%h/%h/%b want=3f800000/40000000/00", fpu_op1, fpu_op2, fpu_operation);
        end
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            req0_valid = 0;
            rsp_ready  = (c == 7);
            #1;
            vectors++; if (rsp_valid !== (c == 7)) begin miscompares++; $display("FAIL single_rsp_valid cycle=%0d got=%b want=%b", c, rsp_valid, (c == 7)); end
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy cycle=%0d got=%b want=1", c, busy); end
        end
        vectors++; if ({rsp_id, rsp_data} !== {1'b0, 32'h4040_0000}) begin miscompares++; $display("FAIL single_rsp got=%h want=040400000", {rsp_id, rsp_data}); end
        @(negedge clk);
        rsp_ready = 0;
        #1;
        vectors++; if ({rsp_valid, busy} !== 2'b00) begin miscompares++; $display("FAIL single_after_pop got=%b want=00", {rsp_valid, busy}); end
    endtask

    task automatic test_contention();
        logic       want_id;
        logic [DW:0] want;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rsp_ready = 1;
            req0_valid = 1; req0_op1 = 32'h100 + i; req0_op2 = 32'h10; req0_operation = 2'(i);
            req1_valid = 1; req1_op1 = 32'h200 + i; req1_op2 = 32'h20; req1_operation = 2'(i + 1);
            #1;
            want_id = 1'(i % 2);
            vectors++; if ({req0_ready, req1_ready} !== {~want_id, want_id}) begin
                miscompares++; $display("FAIL contention_grant cycle=%0d got=%b want=%b", i, {req0_ready, req1_ready}, {~want_id, want_id});
            end
            vectors++; if (fpu_op1 !== (want_id ? req1_op1 : req0_op1)) begin
                miscompares++; $display("FAIL contention_fpu_op1 cycle=%0d got=%h want=%h", i, fpu_op1, (want_id ? req1_op1 : req0_op1));
            end
            exp_q.push_back(want_id ? {1'b1, fpu_model(req1_operation, req1_op1, req1_op2)}
                                    : {1'b0, fpu_model(req0_operation, req0_op1, req0_op2)});
            if (rsp_valid) begin
                want = exp_q.pop_front();
                vectors++; if ({rsp_id, rsp_data} !== want) begin miscompares++; $display("FAIL contention_rsp got=%h want=%h", {rsp_id, rsp_data}, want); end
            end
        end
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            req0_valid = 0; req1_valid = 0; rsp_ready = 1;
            #1;
            if (rsp_valid) begin
                want = exp_q.pop_front();
                vectors++; if ({rsp_id, rsp_data} !== want) begin miscompares++; $display("FAIL contention_rsp got=%h want=%h", {rsp_id, rsp_data}, want); end
            end
        end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL contention_drain_timeout left=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int          grants;
        logic [DW:0] want;
        do_reset();
        grants = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            rsp_ready = 0; req0_valid = 1; req0_op1 = 32'h1000 + i; req0_op2 = 32'h1; req0_operation = 2'b00;
            #1;
            if (req0_ready) begin grants++; exp_q.push_back({1'b0, fpu_model(2'b00, req0_op1, req0_op2)}); end
        end
        vectors++; if (grants != 8) begin miscompares++; $display("FAIL bp_grants got=%0d want=8", grants); end
        vectors++; if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL bp_stalled_ready got=%b want=0", req0_ready); end
        @(negedge clk);
        rsp_ready = 1;
        #1;
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_pop_valid got=%b want=1", rsp_valid); end
        vectors++; if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL bp_pop_cycle_ready got=%b want=0", req0_ready); end
        want = exp_q.pop_front();
        vectors++; if ({rsp_id, rsp_data} !== want) begin miscompares++; $display("FAIL bp_pop_data got=%h want=%h", {rsp_id, rsp_data}, want); end
        grants = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rsp_ready = 0; req0_valid = 1; req0_op1 = 32'h1800 + i;
            #1;
            if (req0_ready) begin grants++; exp_q.push_back({1'b0, fpu_model(2'b00, req0_op1, req0_op2)}); end
        end
        vectors++; if (grants != 1) begin miscompares++; $display("FAIL bp_regrant got=%0d want=1", grants); end
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            req0_valid = 0; rsp_ready = 1;
            #1;
            if (rsp_valid) begin
                want = exp_q.pop_front();
                vectors++; if ({rsp_id, rsp_data} !== want) begin miscompares++; $display("FAIL bp_rsp got=%h want=%h", {rsp_id, rsp_data}, want); end
            end
        end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL bp_drain_timeout left=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_simultaneous();
        int          grants;
        logic [DW:0] want;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rsp_ready = (i == 9);
            req0_valid = (i < 4); req0_op1 = 32'h2000 + i; req0_op2 = 32'h2; req0_operation = 2'b01;
            #1;
            if (i < 4) begin
                vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL simul_issue cycle=%0d got=%b want=1", i, req0_ready); end
                exp_q.push_back({1'b0, fpu_model(2'b01, req0_op1, req0_op2)});
            end
        end
        // Cycle 9: three entries held, fourth result pushing, head popping.
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL simul_pop_valid got=%b want=1", rsp_valid); end
        want = exp_q.pop_front();
        vectors++; if ({rsp_id, rsp_data} !== want) begin miscompares++; $display("FAIL simul_pop_data got=%h want=%h", {rsp_id, rsp_data}, want); end
        grants = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rsp_ready = 0; req0_valid = 1; req0_op1 = 32'h3000 + i; req0_op2 = 32'h3; req0_operation = 2'b10;
            #1;
            if (req0_ready) begin grants++; exp_q.push_back({1'b0, fpu_model(2'b10, req0_op1, req0_op2)}); end
        end
        vectors++; if (grants != 5) begin miscompares++; $display("FAIL simul_credit_after got=%0d want=5", grants); end
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            req0_valid = 0; rsp_ready = 1;
            #1;
            if (rsp_valid) begin
                want = exp_q.pop_front();
                vectors++; if ({rsp_id, rsp_data} !== want) begin miscompares++; $display("FAIL simul_rsp got=%h want=%h", {rsp_id, rsp_data}, want); end
            end
        end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL simul_drain_timeout left=%0d want=0", exp_q.size()); end
        @(negedge clk);
        rsp_ready = 0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL simul_busy_end got=%b want=0", busy); end
    endtask

    task automatic test_midflight_reset();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rsp_ready = 1; req1_valid = (i < 4); req1_op1 = 32'h4000 + i; req1_op2 = 32'h4; req1_operation = 2'b11;
            #1;
        end
        @(negedge clk);
        req1_valid = 0;
        rst = 1;
        #1;
        vectors++; if ({rsp_valid, busy} !== 2'b00) begin miscompares++; $display("FAIL midrst_immediate got=%b want=00", {rsp_valid, busy}); end
        @(negedge clk);
        rst = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            rsp_ready = 1;
            #1;
            vectors++; if ({rsp_valid, busy} !== 2'b00) begin miscompares++; $display("FAIL midrst_stale cycle=%0d got=%b want=00", c, {rsp_valid, busy}); end
        end
    endtask

    task automatic test_idle();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req0_valid = 0; req1_valid = 0; rsp_ready = c[0];
            req0_op1 = 32'hDEAD_BEEF; req0_op2 = 32'hCAFE_F00D; req0_operation = 2'b11;
            req1_op1 = 32'h1234_5678; req1_op2 = 32'h8765_4321; req1_operation = 2'b10;
            #1;
            vectors++; if ({fpu_op1, fpu_op2, fpu_operation} !== 66'd0) begin
                miscompares++; $display("FAIL idle_fpu cycle=%0d got=%h/%h/%b want=0", c, fpu_op1, fpu_op2, fpu_operation);
            end
            vectors++; if ({busy, req0_ready, req1_ready} !== 3'b000) begin
                miscompares++; $display("FAIL idle_status cycle=%0d got=%b want=000", c, {busy, req0_ready, req1_ready});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW:0] want;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rsp_ready = 1; req0_valid = 1; req0_op1 = 32'h5000 + i; req0_op2 = 32'h5; req0_operation = 2'b10;
            #1;
            vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready cycle=%0d got=%b want=1", i, req0_ready); end
            if (req0_ready) exp_q.push_back({1'b0, fpu_model(2'b10, req0_op1, req0_op2)});
            if (rsp_valid) begin
                want = exp_q.pop_front();
                vectors++; if ({rsp_id, rsp_data} !== want) begin miscompares++; $display("FAIL b2b_rsp got=%h want=%h", {rsp_id, rsp_data}, want); end
            end
        end
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            req0_valid = 0; rsp_ready = 1;
            #1;
            if (rsp_valid) begin
                want = exp_q.pop_front();
                vectors++; if ({rsp_id, rsp_data} !== want) begin miscompares++; $display("FAIL b2b_rsp got=%h want=%h", {rsp_id, rsp_data}, want); end
            end
        end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_drain_timeout left=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1;
        clear_inputs();
        test_reset();
        test_single_op();
        test_contention();
        test_backpressure();
        test_simultaneous();
        test_midflight_reset();
        test_idle();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
